median_wrapper: RTL and testbench

//  Avalon-MM slave that streams an RGB image (256 px/row, 24 bpp) into a 3-row line window.

---
 rtl/median_pkg.sv | 38 +++
 rtl/median_core.sv | 73 +++++++
 rtl/median_wrapper.sv | 119 +++++++++++
 tb/tb_median_wrapper.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : median_pkg
//  Description : Shared geometry, bus address map and FSM encoding for the
//                3x3 RGB median filter slave (median_wrapper / median_core).
//  Contents    : COL, WIDTH, PIX_W, ROW_BITS, WORDS, ADDR_* constants,
//                FSM state enum and encodings, pixel offset helper.
//  Revision    : 1.0  initial release
// ============================================================================
package median_pkg;

   localparam int COL      = 256;             // pixels per row
   localparam int WIDTH    = 8;               // bits per colour channel
   localparam int PIX_W    = 3 * WIDTH;       // R,G,B with R in the MSBs
   localparam int ROW_BITS = COL * PIX_W;     // 6144
   localparam int WORDS    = ROW_BITS / 32;   // 192 bus words per row

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_OUT    = 2'b10;
   localparam logic [1:0] ADDR_CTRL   = 2'b11;

   typedef enum logic [0:0] {
      FILL   = 1'b0,
      COMMIT = 1'b1
   } median_state_e;

   localparam logic [0:0] ST_FILL   = FILL;
   localparam logic [0:0] ST_COMMIT = COMMIT;

   // Pixel 0 sits at the top of a row vector, so column c occupies the
   // PIX_W bits starting at this LSB position.
   function automatic int pix_lsb(input int c);
      return (COL - 1 - c) * PIX_W;
   endfunction

endpackage : median_pkg
`default_nettype wire

// File: rtl/median_core.sv
`default_nettype none
// ============================================================================
//  Module      : median9 / median_core
//  Description : median9  - 9-input 8-bit median, 19 compare-exchange network,
//                           purely combinational.
//                median_core - per-channel 3x3 median over three line
//                           registers with edge-clamped columns.
//  Ports       : median9     vals[8:0][7:0] in, med[7:0] out
//                median_core i_line_top/mid/bot[ROW_BITS-1:0] in,
//                            row_out[ROW_BITS-1:0] out (same pixel order)
//  Revision    : 1.0  initial release
// ============================================================================
module median9 (
   input  logic [8:0][7:0] vals,
   output logic [7:0]      med
);

   // Compare-exchange pairs: after each step p[A] <= p[B]. The final
   // partial network only guarantees p[4] is the median, not a full sort.
   localparam int NET_A [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
   localparam int NET_B [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

   logic [7:0] w_p [9];

   always_comb begin
      logic [7:0] v_tmp;
      v_tmp = '0;
      for (int i = 0; i < 9; i++) begin
         w_p[i] = vals[i];
      end
      for (int s = 0; s < 19; s++) begin
         if (w_p[NET_A[s]] > w_p[NET_B[s]]) begin
            v_tmp          = w_p[NET_A[s]];
            w_p[NET_A[s]]  = w_p[NET_B[s]];
            w_p[NET_B[s]]  = v_tmp;
         end
      end
      med = w_p[4];
   end

endmodule : median9

module median_core
   import median_pkg::*;
(
   input  logic [ROW_BITS-1:0] i_line_top,
   input  logic [ROW_BITS-1:0] i_line_mid,
   input  logic [ROW_BITS-1:0] i_line_bot,
   output logic [ROW_BITS-1:0] row_out
);

   for (genvar c = 0; c < COL; c++) begin : g_col
      // Out-of-range neighbours replicate the edge column.
      localparam int CL = (c == 0)       ? 0       : c - 1;
      localparam int CR = (c == COL - 1) ? COL - 1 : c + 1;

      for (genvar k = 0; k < 3; k++) begin : g_ch
         localparam int OFF = (2 - k) * WIDTH;   // k=0 is red (MSBs)
         localparam int LL  = pix_lsb(CL) + OFF;
         localparam int LC  = pix_lsb(c)  + OFF;
         localparam int LR  = pix_lsb(CR) + OFF;

         median9 u_med9 (
            .vals ({i_line_top[LL +: WIDTH], i_line_top[LC +: WIDTH], i_line_top[LR +: WIDTH],
                    i_line_mid[LL +: WIDTH], i_line_mid[LC +: WIDTH], i_line_mid[LR +: WIDTH],
                    i_line_bot[LL +: WIDTH], i_line_bot[LC +: WIDTH], i_line_bot[LR +: WIDTH]}),
            .med  (row_out[LC +: WIDTH])
         );
      end
   end

endmodule : median_core
`default_nettype wire

// File: rtl/median_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : median_wrapper
//  Description : Avalon-MM slave that collects 192-word RGB rows into a
//                three-line window and exposes the 3x3 median-filtered row.
//  Ports       : clk, rst_n (async, active-high), ChipSelect, Write, Read,
//                Address[1:0] (00 data in, 01 status, 10 filtered out,
//                11 control), WriteData[31:0], ReadData[31:0] (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module median_wrapper
   import median_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ChipSelect,
   input  logic        Write,
   input  logic        Read,
   input  logic [1:0]  Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData
);

   localparam logic [7:0] c_last_word = 8'(WORDS - 1);

   logic [0:0]          r_state;
   logic [7:0]          r_word_cnt;
   logic [7:0]          r_rd_ptr;
   logic [7:0]          r_row_cnt;
   logic [ROW_BITS-1:0] r_in_sr;
   logic [ROW_BITS-1:0] r_line_top;
   logic [ROW_BITS-1:0] r_line_mid;
   logic [ROW_BITS-1:0] r_line_bot;

   logic                w_wr;
   logic                w_rd;
   logic                w_soft_clr;
   logic                w_valid;
   logic [7:0]          w_word_idx;
   logic [ROW_BITS-1:0] w_row_out;

   assign w_wr       = ChipSelect & Write;
   assign w_rd       = ChipSelect & Read;
   assign w_soft_clr = w_wr && (Address == ADDR_CTRL) && WriteData[0];
   // The first two commits only prime the window.
   assign w_valid    = (r_row_cnt >= 8'd3);
   // rd_ptr counts words from the top of the row vector.
   assign w_word_idx = c_last_word - r_rd_ptr;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state    <= ST_FILL;
         r_word_cnt <= '0;
         r_rd_ptr   <= '0;
         r_row_cnt  <= '0;
         r_in_sr    <= '0;
         r_line_top <= '0;
         r_line_mid <= '0;
         r_line_bot <= '0;
      end else if (w_soft_clr) begin
         r_state    <= ST_FILL;
         r_word_cnt <= '0;
         r_rd_ptr   <= '0;
         r_row_cnt  <= '0;
         r_in_sr    <= '0;
         r_line_top <= '0;
         r_line_mid <= '0;
         r_line_bot <= '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_wr && (Address == ADDR_DATA)) begin
                  r_in_sr <= {r_in_sr[ROW_BITS-33:0], WriteData};
                  if (r_word_cnt == c_last_word) begin
                     r_word_cnt <= '0;
                     r_state    <= ST_COMMIT;
                  end else begin
                     r_word_cnt <= r_word_cnt + 8'd1;
                  end
               end
               if (w_rd && (Address == ADDR_OUT)) begin
                  r_rd_ptr <= (r_rd_ptr == c_last_word) ? 8'd0 : r_rd_ptr + 8'd1;
               end
            end
            default: begin
               // COMMIT: one cycle, bus writes are dropped here.
               r_line_top <= r_line_mid;
               r_line_mid <= r_line_bot;
               r_line_bot <= r_in_sr;
               if (r_row_cnt != 8'hFF) begin
                  r_row_cnt <= r_row_cnt + 8'd1;
               end
               r_rd_ptr   <= '0;
               r_state    <= ST_FILL;
            end
         endcase
      end
   end

   median_core CORE (
      .i_line_top (r_line_top),
      .i_line_mid (r_line_mid),
      .i_line_bot (r_line_bot),
      .row_out    (w_row_out)
   );

   always_comb begin
      ReadData = '0;
      if (w_rd) begin
         case (Address)
            ADDR_STATUS: ReadData = {16'b0, r_row_cnt, 6'b0, (r_state == ST_COMMIT), w_valid};
            ADDR_OUT:    ReadData = w_row_out[{w_word_idx, 5'b0} +: 32];
            default:     ReadData = '0;
         endcase
      end
   end

endmodule : median_wrapper
`default_nettype wire

// File: tb/tb_median_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_median_wrapper
//  Description : Self-checking bench for median_wrapper. A reference model
//                of the line window computes each filtered row by sorting,
//                and pushes expected words into a scoreboard queue on every
//                valid commit; Addr-10 reads pop and compare.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_median_wrapper;
   import median_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ChipSelect;
   logic        Write;
   logic        Read;
   logic [1:0]  Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   always #5 clk = ~clk;

   median_wrapper dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ChipSelect (ChipSelect),
      .Write      (Write),
      .Read       (Read),
      .Address    (Address),
      .WriteData  (WriteData),
      .ReadData   (ReadData)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [ROW_BITS-1:0] m_top, m_mid, m_bot;
   int                  m_cnt;
   logic [31:0]         sb[$];
   logic [31:0]         got_words [WORDS];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [23:0] get_pix(input logic [ROW_BITS-1:0] r, input int c);
      return r[ROW_BITS-1-24*c -: 24];
   endfunction

   function automatic logic [7:0] med_ref(input logic [7:0] v [9]);
      logic [7:0] a [9];
      logic [7:0] t;
      a = v;
      for (int i = 1; i < 9; i++) begin
         for (int j = i; j > 0; j--) begin
            if (a[j-1] > a[j]) begin
               t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
         end
      end
      return a[4];
   endfunction

   function automatic logic [ROW_BITS-1:0] model_out();
      logic [ROW_BITS-1:0] res;
      logic [7:0]          v [9];
      int                  cols [3];
      logic [23:0]         p;
      res = '0;
      for (int c = 0; c < COL; c++) begin
         cols[0] = (c == 0) ? 0 : c - 1;
         cols[1] = c;
         cols[2] = (c == COL - 1) ? COL - 1 : c + 1;
         for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 3; n++) begin
               p = get_pix(m_top, cols[n]); v[n]     = p[23-8*k -: 8];
               p = get_pix(m_mid, cols[n]); v[3 + n] = p[23-8*k -: 8];
               p = get_pix(m_bot, cols[n]); v[6 + n] = p[23-8*k -: 8];
            end
            res[ROW_BITS-1-24*c-8*k -: 8] = med_ref(v);
         end
      end
      return res;
   endfunction

   task automatic model_clear();
      m_top = '0; m_mid = '0; m_bot = '0; m_cnt = 0;
      sb.delete();
   endtask

   task automatic model_commit(input logic [ROW_BITS-1:0] row);
      logic [ROW_BITS-1:0] e;
      m_top = m_mid; m_mid = m_bot; m_bot = row;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt >= 3) begin
         e = model_out();
         for (int w = 0; w < WORDS; w++) sb.push_back(e[ROW_BITS-1-32*w -: 32]);
      end
   endtask

   function automatic logic [ROW_BITS-1:0] const_row(input logic [23:0] px);
      logic [ROW_BITS-1:0] r;
      for (int c = 0; c < COL; c++) r[ROW_BITS-1-24*c -: 24] = px;
      return r;
   endfunction

   function automatic logic [ROW_BITS-1:0] rand_row();
      logic [ROW_BITS-1:0] r;
      for (int w = 0; w < WORDS; w++) r[ROW_BITS-1-32*w -: 32] = $urandom;
      return r;
   endfunction

   // ---------------- bus tasks ----------------
   task automatic bus_idle();
      @(negedge clk);
      ChipSelect = 1'b0; Write = 1'b0; Read = 1'b0; Address = 2'b00; WriteData = '0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      ChipSelect = 1'b1; Write = 1'b1; Read = 1'b0; Address = a; WriteData = d;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      ChipSelect = 1'b1; Write = 1'b0; Read = 1'b1; Address = a; WriteData = '0;
      #1 d = ReadData;
   endtask

   // 192 data words plus the commit cycle. Normally the commit cycle carries
   // a junk write that must be dropped; optionally it samples status instead.
   task automatic write_row(input logic [ROW_BITS-1:0] row, input bit status_in_commit);
      logic [31:0] d;
      for (int w = 0; w < WORDS; w++) bus_write(ADDR_DATA, row[ROW_BITS-1-32*w -: 32]);
      if (status_in_commit) begin
         bus_read(ADDR_STATUS, d);
         check("commit_status", d, {16'b0, 8'(m_cnt), 6'b0, 1'b1, (m_cnt >= 3)});
      end else begin
         bus_write(ADDR_DATA, 32'hDEADBEEF);
      end
      bus_idle();
      model_commit(row);
   endtask

   task automatic read_row();
      logic [31:0] d;
      for (int w = 0; w < WORDS; w++) begin
         bus_read(ADDR_OUT, d);
         got_words[w] = d;
         if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else check($sformatf("row_word[%0d]", w), d, sb.pop_front());
      end
      bus_idle();
   endtask

   task automatic check_status(input string tag, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(ADDR_STATUS, d);
      bus_idle();
      check(tag, d, exp);
   endtask

   task automatic soft_clear();
      bus_write(ADDR_CTRL, 32'h0000_0001);
      bus_idle();
      model_clear();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0]         d;
      logic [ROW_BITS-1:0] r, e;

      ChipSelect = 1'b0; Write = 1'b0; Read = 1'b0; Address = 2'b00; WriteData = '0;
      model_clear();

      // 1. reset
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_readdata", ReadData, 32'h0);
      rst_n = 1'b0;
      check_status("rst_status", 32'h0);
      check("rst_core_zero", {31'b0, |dut.CORE.row_out}, 32'h0);
      bus_read(ADDR_DATA, d); bus_idle(); check("rd_addr00", d, 32'h0);
      bus_read(ADDR_CTRL, d); bus_idle(); check("rd_addr11", d, 32'h0);

      // 2. three constant rows
      r = const_row(24'h404040);
      write_row(r, 1'b1);
      write_row(r, 1'b0);
      check_status("status_2rows", 32'h0000_0200);
      write_row(r, 1'b0);
      check_status("status_3rows", 32'h0000_0301);
      @(negedge clk);
      ChipSelect = 1'b1; Read = 1'b0; Write = 1'b0; Address = ADDR_OUT;
      #1 check("no_read_zero", ReadData, 32'h0);
      bus_idle();
      read_row();
      check("const_word0", got_words[0], 32'h40404040);
      check("const_word191", got_words[WORDS-1], 32'h40404040);
      // read pointer wraps back to word 0
      e = model_out();
      sb.push_back(e[ROW_BITS-1 -: 32]);
      bus_read(ADDR_OUT, d); bus_idle();
      check("rd_ptr_wrap", d, sb.pop_front());

      // 3. salt noise in the middle row
      soft_clear();
      check_status("softclr_status", 32'h0);
      r = const_row(24'h102030);
      write_row(r, 1'b0);
      e = r; e[ROW_BITS-1-24*100 -: 24] = 24'hFFFFFF;
      write_row(e, 1'b0);
      write_row(r, 1'b1);
      read_row();
      check("salt_px100", got_words[75], 32'h10203010);

      // 4. edge clamp
      soft_clear();
      r = const_row(24'h808080);
      r[ROW_BITS-1 -: 24] = 24'h000000;
      for (int i = 0; i < 3; i++) write_row(r, 1'b0);
      read_row();
      check("edge_word0", got_words[0], 32'h00000080);
      check("edge_word1", got_words[1], 32'h80808080);

      // 5. junk writes in commit cycles over five random rows
      soft_clear();
      for (int i = 1; i <= 5; i++) begin
         write_row(rand_row(), 1'b0);
         if (i >= 3) read_row();
      end
      check_status("status_5rows", 32'h0000_0501);

      // 6a. reset pulse mid-row
      for (int w = 0; w < 50; w++) bus_write(ADDR_DATA, $urandom);
      bus_idle();
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) rst_n = 1'b0;
      model_clear();
      write_row(rand_row(), 1'b0);
      check_status("midrow_rst_status", 32'h0000_0100);

      // 6b. soft clear mid-row
      write_row(rand_row(), 1'b0);
      for (int w = 0; w < 50; w++) bus_write(ADDR_DATA, $urandom);
      soft_clear();
      write_row(rand_row(), 1'b0);
      check_status("midrow_clr_status", 32'h0000_0100);

      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_median_wrapper
`default_nettype wire
